// File: rtl/atd_pkg.sv
// rtl/atd_pkg.sv - shared state encoding and line idle levels for the ATD link
package atd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_HIGH,
    CLK_LOW,
    DONE
  } atd_tx_state_t;

  localparam logic ATD_IDLE_DATA = 1'b1;
  localparam logic ATD_IDLE_CLK  = 1'b0;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter that flags the cycle it wraps at rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  // Flag marks the last of rollover_val counted cycles so the caller can act on that same edge.
  assign rollover_flag = count_enable && (count_q == rollover_val - CNT_ONE);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = rollover_flag ? '0 : count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/atd_transmitter.sv
// rtl/atd_transmitter.sv - ATD link serial transmitter, MSB-first, data changes only while ATD_clk is low
module atd_transmitter
  import atd_pkg::*;
#(
  parameter int NUM_BITS     = 8,
  parameter int CLK_DIV      = 4,
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                ATD_clk,
  output logic                ATD_data,
  output logic                ATD_data_oe,
  output logic                busy,
  output logic                tx_done
);

  atd_tx_state_t       state_q, state_d;
  logic [NUM_BITS-1:0] shift_q, shift_d, shifted;
  logic clk_q, clk_d, data_q, data_d, oe_q, oe_d;
  logic busy_q, busy_d, done_q, done_d, ready_q, ready_d, last_q, last_d;
  logic div_clear, div_en, div_flag, bit_clear, bit_en, bit_flag;

  assign div_en    = (state_q == SETUP) || (state_q == CLK_HIGH) || (state_q == CLK_LOW);
  assign div_clear = (state_d != state_q);
  assign bit_clear = (state_q == IDLE);
  assign bit_en    = (state_q == CLK_HIGH) && div_flag;
  assign shifted   = shift_q << 1;

  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_div_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (div_clear),
    .count_enable (div_en),
    .rollover_val (NUM_CNT_BITS'(CLK_DIV)),
    .rollover_flag(div_flag)
  );

  flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (bit_clear),
    .count_enable (bit_en),
    .rollover_val (NUM_CNT_BITS'(NUM_BITS)),
    .rollover_flag(bit_flag)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    clk_d   = clk_q;
    data_d  = data_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ready_d = ready_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          data_d  = tx_data[NUM_BITS-1];
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_flag) begin
          clk_d   = 1'b1;
          state_d = CLK_HIGH;
        end
      end
      CLK_HIGH: begin
        if (div_flag) begin
          clk_d   = ATD_IDLE_CLK;
          last_d  = bit_flag;
          state_d = CLK_LOW;
          // The final low phase holds the last bit instead of shifting in a stale zero.
          if (!bit_flag) begin
            shift_d = shifted;
            data_d  = shifted[NUM_BITS-1];
          end
        end
      end
      CLK_LOW: begin
        if (div_flag) begin
          if (last_q) begin
            done_d  = 1'b1;
            data_d  = ATD_IDLE_DATA;
            oe_d    = 1'b0;
            state_d = DONE;
          end else begin
            clk_d   = 1'b1;
            state_d = CLK_HIGH;
          end
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      clk_q   <= ATD_IDLE_CLK;
      data_q  <= ATD_IDLE_DATA;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      clk_q   <= clk_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      last_q  <= last_d;
    end
  end

  assign tx_ready    = ready_q;
  assign ATD_clk     = clk_q;
  assign ATD_data    = data_q;
  assign ATD_data_oe = oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;

endmodule

// File: tb/tb_atd_transmitter.sv
// tb/tb_atd_transmitter.sv - self-checking bench for atd_transmitter (default and small configurations)
module tb_atd_transmitter;

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ATD_clk, ATD_data, ATD_data_oe, busy, tx_done;
  logic [3:0] tx_data2;
  logic       tx_valid2;
  logic       s_ready, s_clk, s_data, s_oe, s_busy, s_done;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  logic mon_prev;
  logic rise_data;

  typedef struct {
    logic [7:0] data;
    logic [7:0] next_data;
    bit         keep_valid;
    int         exp_rises;
    int         exp_first_rise;
    int         exp_done_at;
    int         exp_busy;
  } frame_t;

  frame_t vec[4];

  atd_transmitter #(.NUM_BITS(8), .CLK_DIV(4), .NUM_CNT_BITS(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ATD_clk    (ATD_clk),
    .ATD_data   (ATD_data),
    .ATD_data_oe(ATD_data_oe),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  atd_transmitter #(.NUM_BITS(4), .CLK_DIV(2), .NUM_CNT_BITS(8)) dut_small (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data2),
    .tx_valid   (tx_valid2),
    .tx_ready   (s_ready),
    .ATD_clk    (s_clk),
    .ATD_data   (s_data),
    .ATD_data_oe(s_oe),
    .busy       (s_busy),
    .tx_done    (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver-side model: pop one expected bit per ATD_clk rise, hold data stable while high.
  always @(negedge clk) begin
    if (!n_rst) begin
      mon_prev = 1'b0;
    end else begin
      if (ATD_clk && !mon_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rise", 1, 0);
        end else begin
          check("rise_bit", int'(ATD_data), int'(exp_q.pop_front()));
        end
        rise_data = ATD_data;
      end else if (ATD_clk && mon_prev) begin
        check("stable_high", int'(ATD_data), int'(rise_data));
      end
      if (!ATD_data_oe) begin
        check("released_data", int'(ATD_data), 1);
        check("released_clk", int'(ATD_clk), 0);
      end
      mon_prev = ATD_clk;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", int'(tx_ready), 1);
  endtask

  task automatic send_frame(input frame_t f);
    int  rises, first_rise, done_at, done_cnt, busy_cnt;
    logic prev;
    wait_ready();
    tx_data  = f.data;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int b = 7; b >= 0; b--) exp_q.push_back(f.data[b]);
    rises = 0; first_rise = -1; done_at = -1; done_cnt = 0; busy_cnt = 0; prev = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0 && !f.keep_valid) tx_valid = 1'b0;
      if (c == 10) tx_data = f.next_data;
      if (ATD_clk && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      prev = ATD_clk;
      if (tx_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (busy) busy_cnt++;
      else break;
    end
    check("rises", rises, f.exp_rises);
    check("first_rise", first_rise, f.exp_first_rise);
    check("done_at", done_at, f.exp_done_at);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cnt, f.exp_busy);
    check("gap_clk", int'(ATD_clk), 0);
    check("gap_oe", int'(ATD_data_oe), 0);
    check("gap_ready", int'(tx_ready), 1);
  endtask

  initial begin
    int rises, busy_cnt, first_rise, run, done_seen;
    logic [3:0] bits;
    logic prev;

    vec[0] = '{8'hA5, 8'h00, 1'b0, 8, 4, 68, 69};
    vec[1] = '{8'h3C, 8'hC3, 1'b0, 8, 4, 68, 69};
    vec[2] = '{8'hFF, 8'h00, 1'b1, 8, 4, 68, 69};
    vec[3] = '{8'h00, 8'h5A, 1'b0, 8, 4, 68, 69};

    n_rst = 1'b0; tx_data = '0; tx_valid = 1'b0; tx_data2 = '0; tx_valid2 = 1'b0;
    mon_prev = 1'b0; rise_data = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk", int'(ATD_clk), 0);
    check("rst_data", int'(ATD_data), 1);
    check("rst_oe", int'(ATD_data_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(tx_done), 0);
    #2 n_rst = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(tx_ready), 1);

    for (int i = 0; i < 4; i++) send_frame(vec[i]);

    // Abort a frame of 8'hF0 just after its third rise.
    wait_ready();
    tx_data = 8'hF0; tx_valid = 1'b1;
    @(posedge clk);
    for (int b = 7; b >= 0; b--) exp_q.push_back(tx_data[b]);
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 200 && rises < 3; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (ATD_clk && !prev) rises++;
      prev = ATD_clk;
    end
    check("abort_rises", rises, 3);
    #2 n_rst = 1'b0;
    #1;
    check("abort_clk", int'(ATD_clk), 0);
    check("abort_data", int'(ATD_data), 1);
    check("abort_oe", int'(ATD_data_oe), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(tx_ready), 1);
    exp_q.delete();
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done || ATD_clk) done_seen++;
    end
    #2 n_rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tx_done || ATD_clk) done_seen++;
    end
    check("abort_quiet", done_seen, 0);
    send_frame('{8'h81, 8'h7E, 1'b0, 8, 4, 68, 69});

    // Small configuration: NUM_BITS=4, CLK_DIV=2.
    tx_data2 = 4'h9; tx_valid2 = 1'b1;
    @(posedge clk);
    rises = 0; busy_cnt = 0; first_rise = -1; run = 0; bits = '0; prev = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tx_valid2 = 1'b0;
      if (s_clk && !prev) begin
        rises++;
        bits = {bits[2:0], s_data};
        if (first_rise < 0) first_rise = c;
      end
      if (s_clk) run++;
      else if (prev) begin
        check("small_high_len", run, 2);
        run = 0;
      end
      prev = s_clk;
      if (s_busy) busy_cnt++;
      else break;
    end
    check("small_rises", rises, 4);
    check("small_bits", int'(bits), 9);
    check("small_first_rise", first_rise, 2);
    check("small_busy", busy_cnt, 19);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
